// File: rtl/button_pkg.sv
// Shared types and default geometry for the purple button / lift controller.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE_DOWN = 2'd0,
    RISING    = 2'd1,
    IDLE_UP   = 2'd2,
    FALLING   = 2'd3
  } lift_state_t;

  localparam int COORD_W          = 10;
  localparam int OFFSET_W         = 7;

  localparam int BTN0_X_DEF       = 172;
  localparam int BTN0_Y_DEF       = 241;
  localparam int BTN1_X_DEF       = 520;
  localparam int BTN1_Y_DEF       = 178;
  localparam int BTN_W_DEF        = 20;
  localparam int BTN_H_DEF        = 10;
  localparam int STEP_DEF         = 1;
  localparam int LIFT_MAX_DEF     = 60;
  localparam int HOLD_FRAMES_DEF  = 8;

  // Half-open interval test lo <= v < lo+len, done in 11 bits so lo+len
  // cannot wrap for any 10-bit box.
  function automatic logic in_range(input logic [COORD_W-1:0] v,
                                    input int lo, input int len);
    logic [COORD_W:0] lo_w;
    logic [COORD_W:0] hi_w;
    lo_w = (COORD_W+1)'(lo);
    hi_w = (COORD_W+1)'(lo + len);
    return ({1'b0, v} >= lo_w) && ({1'b0, v} < hi_w);
  endfunction

endpackage

// File: rtl/button_press_latch.sv
// One floor button: occupancy compare against both players' feet, the
// release hold counter and the registered push flag. All updates are gated
// by the frame tick.
// Build option: BUTTON_LIFT_LATCH_EN makes the push flag one-shot (sticky
// until reset) and removes the hold counter.
module button_press_latch
  import button_pkg::*;
#(
  parameter int BTN_X       = BTN0_X_DEF,
  parameter int BTN_Y       = BTN0_Y_DEF,
  parameter int BTN_W       = BTN_W_DEF,
  parameter int BTN_H       = BTN_H_DEF,
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic [COORD_W-1:0] p0_x_i,
  input  logic [COORD_W-1:0] p0_y_i,
  input  logic [COORD_W-1:0] p1_x_i,
  input  logic [COORD_W-1:0] p1_y_i,
  output logic               push_o
);

  logic occupied;
  logic push_q, push_d;

  // Either foot inside the hit box occupies the button.
  always_comb begin
    occupied = (in_range(p0_x_i, BTN_X, BTN_W) && in_range(p0_y_i, BTN_Y, BTN_H)) ||
               (in_range(p1_x_i, BTN_X, BTN_W) && in_range(p1_y_i, BTN_Y, BTN_H));
  end

`ifdef BUTTON_LIFT_LATCH_EN
  // One-shot press: once set the flag never clears before reset.
  always_comb begin
    push_d = push_q;
    if (tick_i && occupied) push_d = 1'b1;
  end
`else
  localparam int                CNT_W    = $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Press sets immediately; release needs HOLD_FRAMES consecutive empty ticks.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    push_d = push_q;
    cnt_d  = cnt_q;
    if (tick_i) begin
      if (occupied) begin
        push_d = 1'b1;
        cnt_d  = '0;
      end else if (push_q) begin
        if (cnt_q == CNT_LAST) begin
          push_d = 1'b0;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  // Push flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking <= so every flop samples pre-edge values.
    if (!rst_n) push_q <= 1'b0;
    else        push_q <= push_d;
  end

  assign push_o = push_q;

endmodule

// File: rtl/button_lift_ctrl.sv
// Purple button / lift controller: synchronises the frame clock into a
// one-Clk tick, runs two button press latches and sequences the shared lift.
// Build option: BUTTON_LIFT_LATCH_EN (one-shot buttons, see button_press_latch).
module button_lift_ctrl
  import button_pkg::*;
#(
  parameter int BTN0_X      = BTN0_X_DEF,
  parameter int BTN0_Y      = BTN0_Y_DEF,
  parameter int BTN1_X      = BTN1_X_DEF,
  parameter int BTN1_Y      = BTN1_Y_DEF,
  parameter int BTN_W       = BTN_W_DEF,
  parameter int BTN_H       = BTN_H_DEF,
  parameter int STEP        = STEP_DEF,
  parameter int LIFT_MAX    = LIFT_MAX_DEF,
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_clk,
  input  logic [COORD_W-1:0]  p0_x,
  input  logic [COORD_W-1:0]  p0_y,
  input  logic [COORD_W-1:0]  p1_x,
  input  logic [COORD_W-1:0]  p1_y,
  output logic                is_button_purple_push1,
  output logic                is_button_purple_push2,
  output logic [OFFSET_W-1:0] lift_offset,
  output logic                lift_moving,
  output logic [1:0]          lift_state
);

  // Offset arithmetic is done one bit wider so offset+STEP cannot wrap.
  localparam logic [OFFSET_W:0] STEP_W = (OFFSET_W+1)'(STEP);
  localparam logic [OFFSET_W:0] MAX_W  = (OFFSET_W+1)'(LIFT_MAX);

  logic [1:0]          sync_q;
  logic                prev_q;
  logic                tick_q;
  logic                push1, push2;
  logic                any_push;
  lift_state_t         state_q, state_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [OFFSET_W:0]   up_sum;
  logic [OFFSET_W-1:0] up_val, down_val;

  // Two-flop synchroniser plus registered rising-edge detect -> one tick per frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], frame_clk};
      prev_q <= sync_q[1];
      tick_q <= sync_q[1] & ~prev_q;
    end
  end

  button_press_latch #(
    .BTN_X(BTN0_X), .BTN_Y(BTN0_Y), .BTN_W(BTN_W), .BTN_H(BTN_H),
    .HOLD_FRAMES(HOLD_FRAMES)
  ) u_btn0 (
    .clk(Clk), .rst_n(Reset_n), .tick_i(tick_q),
    .p0_x_i(p0_x), .p0_y_i(p0_y), .p1_x_i(p1_x), .p1_y_i(p1_y),
    .push_o(push1)
  );

  button_press_latch #(
    .BTN_X(BTN1_X), .BTN_Y(BTN1_Y), .BTN_W(BTN_W), .BTN_H(BTN_H),
    .HOLD_FRAMES(HOLD_FRAMES)
  ) u_btn1 (
    .clk(Clk), .rst_n(Reset_n), .tick_i(tick_q),
    .p0_x_i(p0_x), .p0_y_i(p0_y), .p1_x_i(p1_x), .p1_y_i(p1_y),
    .push_o(push2)
  );

  // Push flags are registers, so the lift always sees the pre-tick values.
  assign any_push = push1 | push2;

  // Saturating step values in both directions.
  always_comb begin
    up_sum   = {1'b0, offset_q} + STEP_W;
    up_val   = (up_sum >= MAX_W) ? MAX_W[OFFSET_W-1:0] : up_sum[OFFSET_W-1:0];
    down_val = ({1'b0, offset_q} <= STEP_W) ? '0 : offset_q - STEP_W[OFFSET_W-1:0];
  end

  // Lift state and offset registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE_DOWN;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
    end
  end

  // Lift next state; a direction reversal spends its tick without moving.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    if (tick_q) begin
      case (state_q)
        IDLE_DOWN: if (any_push) state_d = RISING;
        RISING: begin
          if (!any_push) begin
            state_d = FALLING;
          end else begin
            offset_d = up_val;
            if ({1'b0, up_val} == MAX_W) state_d = IDLE_UP;
          end
        end
        IDLE_UP: if (!any_push) state_d = FALLING;
        FALLING: begin
          if (any_push) begin
            state_d = RISING;
          end else begin
            offset_d = down_val;
            if (down_val == '0) state_d = IDLE_DOWN;
          end
        end
        default: state_d = IDLE_DOWN;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    is_button_purple_push1 = push1;
    is_button_purple_push2 = push2;
    lift_offset            = offset_q;
    lift_state             = state_q;
    lift_moving            = (state_q == RISING) || (state_q == FALLING);
  end

endmodule

// File: tb/tb_button_lift_ctrl.sv
// Scoreboard bench for button_lift_ctrl: two instances (STEP=1 and STEP=7)
// share one stimulus; a frame-level reference model predicts flags, lift
// offset and lift state after every frame.
module tb_button_lift_ctrl;
  import button_pkg::*;

  localparam int B0X = 172, B0Y = 241, B1X = 520, B1Y = 178;
  localparam int BW = 20, BH = 10, LMAX = 60, HOLD = 8;
  localparam int STEP_A = 1, STEP_B = 7;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [9:0] p0_x = '0, p0_y = '0, p1_x = '0, p1_y = '0;

  logic       a_push1, a_push2, a_moving, b_push1, b_push2, b_moving;
  logic [6:0] a_off, b_off;
  logic [1:0] a_state, b_state;

  button_lift_ctrl dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .p0_x(p0_x), .p0_y(p0_y), .p1_x(p1_x), .p1_y(p1_y),
    .is_button_purple_push1(a_push1), .is_button_purple_push2(a_push2),
    .lift_offset(a_off), .lift_moving(a_moving), .lift_state(a_state)
  );

  button_lift_ctrl #(.STEP(STEP_B)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .p0_x(p0_x), .p0_y(p0_y), .p1_x(p1_x), .p1_y(p1_y),
    .is_button_purple_push1(b_push1), .is_button_purple_push2(b_push2),
    .lift_offset(b_off), .lift_moving(b_moving), .lift_state(b_state)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  typedef struct {
    int due;
    int p1, p2, off_a, st_a, off_b, st_b;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (frame granularity) ----------------
  // mode: 0 parked low, 1 going up, 2 parked high, 3 going down
  int m_push[2], m_empty[2], m_mode[2], m_off[2];
  int steps[2] = '{STEP_A, STEP_B};

  function automatic bit in_box(int x, int y, int bx, int by);
    return (x >= bx) && (x < bx + BW) && (y >= by) && (y < by + BH);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_push[k] = 0; m_empty[k] = 0; m_mode[k] = 0; m_off[k] = 0;
    end
  endtask

  task automatic model_frame(int x0, int y0, int x1, int y1);
    bit any_old;
    bit occ[2];
    any_old = (m_push[0] != 0) || (m_push[1] != 0);
    for (int l = 0; l < 2; l++) begin
      case (m_mode[l])
        0: if (any_old) m_mode[l] = 1;
        1: if (!any_old) m_mode[l] = 3;
           else begin
             m_off[l] = (m_off[l] + steps[l] > LMAX) ? LMAX : m_off[l] + steps[l];
             if (m_off[l] == LMAX) m_mode[l] = 2;
           end
        2: if (!any_old) m_mode[l] = 3;
        default: if (any_old) m_mode[l] = 1;
           else begin
             m_off[l] = (m_off[l] - steps[l] < 0) ? 0 : m_off[l] - steps[l];
             if (m_off[l] == 0) m_mode[l] = 0;
           end
      endcase
    end
    occ[0] = in_box(x0, y0, B0X, B0Y) || in_box(x1, y1, B0X, B0Y);
    occ[1] = in_box(x0, y0, B1X, B1Y) || in_box(x1, y1, B1X, B1Y);
    for (int k = 0; k < 2; k++) begin
`ifdef BUTTON_LIFT_LATCH_EN
      if (occ[k]) m_push[k] = 1;
`else
      if (occ[k]) begin
        m_push[k] = 1; m_empty[k] = 0;
      end else if (m_push[k] != 0) begin
        m_empty[k]++;
        if (m_empty[k] == HOLD) begin
          m_push[k] = 0; m_empty[k] = 0;
        end
      end
`endif
    end
  endtask

  task automatic push_exp(int due);
    exp_t e;
    e.due = due;
    e.p1 = m_push[0]; e.p2 = m_push[1];
    e.off_a = m_off[0]; e.st_a = m_mode[0];
    e.off_b = m_off[1]; e.st_b = m_mode[1];
    sb_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        check("push1_a", 32'(a_push1), 32'(e.p1));
        check("push2_a", 32'(a_push2), 32'(e.p2));
        check("offset_a", 32'(a_off), 32'(e.off_a));
        check("state_a", 32'(a_state), 32'(e.st_a));
        check("moving_a", 32'(a_moving), 32'(e.st_a == 1 || e.st_a == 3));
        check("push1_b", 32'(b_push1), 32'(e.p1));
        check("offset_b", 32'(b_off), 32'(e.off_b));
        check("state_b", 32'(b_state), 32'(e.st_b));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic frame(int x0, int y0, int x1, int y1);
    @(negedge Clk);
    p0_x = 10'(x0); p0_y = 10'(y0); p1_x = 10'(x1); p1_y = 10'(y1);
    frame_clk = 1'b1;
    model_frame(x0, y0, x1, y1);
    push_exp(cyc + 6);
    repeat (5) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (5) @(negedge Clk);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() > 0 && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
  endtask

  task automatic do_reset(bit check_now);
    drain();
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    model_reset();
    if (check_now) begin
      #1;
      check("rst_offset_a", 32'(a_off), 0);
      check("rst_state_a", 32'(a_state), 0);
      check("rst_moving_a", 32'(a_moving), 0);
      check("rst_push1_a", 32'(a_push1), 0);
      check("rst_push2_a", 32'(a_push2), 0);
      check("rst_offset_b", 32'(b_off), 0);
    end
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic rand_pos(output int x, output int y);
    case ($urandom_range(0, 3))
      0: begin x = B0X - 3 + $urandom_range(0, BW + 5); y = B0Y - 2 + $urandom_range(0, BH + 3); end
      1: begin x = B1X - 3 + $urandom_range(0, BW + 5); y = B1Y - 2 + $urandom_range(0, BH + 3); end
      default: begin x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int x0, y0, x1, y1, len, done;
    model_reset();
    repeat (3) @(negedge Clk);
    check("init_offset", 32'(a_off), 0);
    check("init_state", 32'(a_state), 0);
    check("init_push1", 32'(a_push1), 0);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);

    // Frame clock idle: standing on both buttons changes nothing.
    p0_x = 10'd180; p0_y = 10'd245; p1_x = 10'd525; p1_y = 10'd180;
    push_exp(cyc + 10);
    push_exp(cyc + 30);
    repeat (35) @(negedge Clk);

    // Hit-box edges that must not press.
    frame(192, 245, 0, 0);
    frame(180, 251, 0, 0);
    frame(171, 245, 0, 0);
    frame(525, 188, 0, 0);

    // Press and hold: rise to the top.
    for (int i = 0; i < 65; i++) frame(180, 245, 0, 0);
    // Step off: debounce, then fall to the bottom.
    for (int i = 0; i < 75; i++) frame(0, 0, 0, 0);

    // Reversal while rising, then the other player re-raises while falling.
    for (int i = 0; i < 40 && !(m_mode[0] == 1 && m_off[0] >= 20); i++) frame(180, 245, 0, 0);
    for (int i = 0; i < 12; i++) frame(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) frame(0, 0, 525, 180);
    for (int i = 0; i < 5; i++) frame(0, 0, 0, 0);

    // Randomised play.
    done = 0;
    while (done < 300) begin
      rand_pos(x0, y0);
      rand_pos(x1, y1);
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) frame(x0, y0, x1, y1);
      done += len;
    end

    // Asynchronous reset while rising at offset 30.
    do_reset(1'b0);
    for (int i = 0; i < 40 && !(m_mode[0] == 1 && m_off[0] == 30); i++) frame(180, 245, 0, 0);
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) frame(0, 0, 0, 0);

    drain();
    check("sb_drain", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
